// File: rtl/bank_burst_ctrl.sv
// bank_burst_ctrl: cycle-level model of one DRAM bank. It tracks the open row, enforces
// tRCD, tRP and CL, and moves wrapped BL-beat bursts for RD and WR commands.
// Optional feature macro: BANK_AUTOPRE_EN. When it is defined, RD or WR with cmd_ap = 1
// precharges the bank after the burst. When it is undefined, cmd_ap is ignored.
module bank_burst_ctrl #(
  parameter int unsigned DEVICE_WIDTH = 4,
  parameter int unsigned ROWS         = 64,
  parameter int unsigned COLS         = 128,
  parameter int unsigned BL           = 8,
  parameter int unsigned CL           = 4,
  parameter int unsigned TRCD         = 3,
  parameter int unsigned TRP          = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd,
  input  logic                     cmd_ap,
  input  logic [$clog2(ROWS)-1:0]  row,
  input  logic [$clog2(COLS)-1:0]  column,
  input  logic [DEVICE_WIDTH-1:0]  dqin,
  output logic [DEVICE_WIDTH-1:0]  dqout,
  output logic                     dq_valid,
  output logic                     cmd_err,
  output logic                     row_open,
  output logic [$clog2(ROWS)-1:0]  open_row
);

  localparam int unsigned CA = $clog2(COLS);
  // One counter serves every timed state, so size it for the longest wait.
  localparam int unsigned CW = $clog2(CL + BL + TRCD + TRP + 2);

  localparam logic [CW-1:0] CL_C   = CW'(CL);
  localparam logic [CW-1:0] BL_C   = CW'(BL);
  localparam logic [CW-1:0] TRCD_C = CW'(TRCD);
  localparam logic [CW-1:0] TRP_C  = CW'(TRP);
  localparam logic [CW-1:0] RD_END = CW'(CL + BL);
  localparam logic [CW-1:0] WR_END = CW'(BL + 1);
  localparam logic [CA-1:0] BL_MASK = CA'(BL - 1);

  localparam logic [1:0] CmdAct = 2'd0;
  localparam logic [1:0] CmdRd  = 2'd1;
  localparam logic [1:0] CmdWr  = 2'd2;
  localparam logic [1:0] CmdPre = 2'd3;

  typedef enum logic [2:0] {
    StIdle, StActivating, StActive, StRdBurst, StWrBurst, StPrecharging
  } state_e;

  state_e                   state;
  logic [CW-1:0]            cnt;   // edges since the command or phase started
  logic [CA-1:0]            col_q;
  logic [DEVICE_WIDTH-1:0]  mem [ROWS][COLS];

  logic [CW-1:0] rd_beat;
  logic [CW-1:0] wr_beat;
  logic [CA-1:0] rd_col;
  logic [CA-1:0] wr_col;
  logic          wr_en;
  logic          burst_done;

`ifdef BANK_AUTOPRE_EN
  logic ap_q;
`else
  logic unused_ap;
  assign unused_ap = cmd_ap;
`endif

  // Wrap the column inside its aligned BL block.
  function automatic logic [CA-1:0] burst_col(input logic [CA-1:0] base,
                                              input logic [CA-1:0] off);
    return (base & ~BL_MASK) | ((base + off) & BL_MASK);
  endfunction

  // Beat addressing and the write strobe for the current burst cycle.
  always_comb begin
    rd_beat    = cnt - CL_C;
    wr_beat    = cnt - CW'(1);
    rd_col     = burst_col(col_q, CA'(rd_beat));
    wr_col     = burst_col(col_q, CA'(wr_beat));
    wr_en      = (state == StWrBurst) && (cnt <= BL_C);
    burst_done = ((state == StRdBurst) && (cnt == RD_END)) ||
                 ((state == StWrBurst) && (cnt == WR_END));
  end

  // Storage is not cleared by reset. A reset edge still blocks the beat that is pending.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) mem[open_row][wr_col] <= dqin;
  end

  // Bank FSM. It drives the registered handshake, status and read-data outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= StIdle;
      cmd_ready <= 1'b1;
      dqout     <= '0;
      dq_valid  <= 1'b0;
      cmd_err   <= 1'b0;
      row_open  <= 1'b0;
      open_row  <= '0;
      cnt       <= '0;
      col_q     <= '0;
`ifdef BANK_AUTOPRE_EN
      ap_q      <= 1'b0;
`endif
    end else begin
      cmd_err <= 1'b0;
      unique case (state)
        StIdle: begin
          if (cmd_valid) begin
            case (cmd)
              CmdAct: begin
                open_row  <= row;
                row_open  <= 1'b1;
                cmd_ready <= 1'b0;
                cnt       <= CW'(1);
                state     <= StActivating;
              end
              CmdPre:  ;
              default: cmd_err <= 1'b1;
            endcase
          end
        end
        StActivating: begin
          if (cnt == TRCD_C) begin
            state     <= StActive;
            cmd_ready <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        StActive: begin
          if (cmd_valid) begin
            case (cmd)
              CmdRd, CmdWr: begin
                col_q     <= column;
                cmd_ready <= 1'b0;
                cnt       <= CW'(1);
                state     <= (cmd == CmdRd) ? StRdBurst : StWrBurst;
`ifdef BANK_AUTOPRE_EN
                ap_q      <= cmd_ap;
`endif
              end
              CmdPre: begin
                row_open  <= 1'b0;
                cmd_ready <= 1'b0;
                cnt       <= CW'(1);
                state     <= StPrecharging;
              end
              default: cmd_err <= 1'b1;
            endcase
          end
        end
        StRdBurst, StWrBurst: begin
          if (burst_done) begin
            dq_valid <= 1'b0;
            dqout    <= '0;
`ifdef BANK_AUTOPRE_EN
            if (ap_q) begin
              row_open <= 1'b0;
              cnt      <= CW'(1);
              state    <= StPrecharging;
            end else begin
              cmd_ready <= 1'b1;
              state     <= StActive;
            end
`else
            cmd_ready <= 1'b1;
            state     <= StActive;
`endif
          end else begin
            cnt <= cnt + CW'(1);
            if ((state == StRdBurst) && (cnt >= CL_C)) begin
              dq_valid <= 1'b1;
              dqout    <= mem[open_row][rd_col];
            end
          end
        end
        StPrecharging: begin
          if (cnt == TRP_C) begin
            state     <= StIdle;
            cmd_ready <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bank_burst_ctrl.sv
// Directed self-checking bench for bank_burst_ctrl with default parameters
// (BL=8, CL=4, TRCD=3, TRP=3). Inputs change 1 ns after a rising edge. Outputs are
// sampled at the same point.
module tb_bank_burst_ctrl;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd;
  logic       cmd_ap;
  logic [5:0] row;
  logic [6:0] column;
  logic [3:0] dqin;
  logic [3:0] dqout;
  logic       dq_valid;
  logic       cmd_err;
  logic       row_open;
  logic [5:0] open_row;

  int total = 0;
  int bad   = 0;

  bank_burst_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd       (cmd),
    .cmd_ap    (cmd_ap),
    .row       (row),
    .column    (column),
    .dqin      (dqin),
    .dqout     (dqout),
    .dq_valid  (dq_valid),
    .cmd_err   (cmd_err),
    .row_open  (row_open),
    .open_row  (open_row)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one command for exactly one edge. The caller has already seen cmd_ready = 1.
  task automatic issue(input logic [1:0] c, input logic [5:0] r, input logic [6:0] col,
                       input logic ap);
    cmd_valid = 1'b1;
    cmd       = c;
    row       = r;
    column    = col;
    cmd_ap    = ap;
    tick();
    cmd_valid = 1'b0;
    cmd_ap    = 1'b0;
  endtask

  // ACT, then check that cmd_ready stays low until edge T+3.
  task automatic act(input logic [5:0] r);
    issue(2'd0, r, 7'd0, 1'b0);
    chk("act_ready_T", cmd_ready, 0);
    chk("act_row_open", row_open, 1);
    chk("act_open_row", open_row, r);
    tick();
    chk("act_ready_T1", cmd_ready, 0);
    tick();
    chk("act_ready_T2", cmd_ready, 0);
    tick();
    chk("act_ready_T3", cmd_ready, 1);
  endtask

  // WR burst: beat i drives data[4i+:4]. cmd_ready comes back at T+9.
  task automatic wr_burst(input logic [6:0] col, input logic [31:0] data);
    issue(2'd2, 6'd0, col, 1'b0);
    for (int i = 0; i < 8; i++) begin
      dqin = data[4*i +: 4];
      tick();
    end
    chk("wr_ready_T8", cmd_ready, 0);
    tick();
    chk("wr_ready_T9", cmd_ready, 1);
  endtask

  // RD burst: dq_valid stays low through T+3, beat i appears at T+4+i, done at T+12.
  task automatic rd_burst(input string tag, input logic [6:0] col, input logic [31:0] exp);
    issue(2'd1, 6'd0, col, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("%s_lat%0d_valid", tag, k), dq_valid, 0);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("%s_beat%0d_valid", tag, i), dq_valid, 1);
      chk($sformatf("%s_beat%0d_data", tag, i), dqout, exp[4*i +: 4]);
      chk($sformatf("%s_beat%0d_ready", tag, i), cmd_ready, 0);
    end
    tick();
    chk({tag, "_end_valid"}, dq_valid, 0);
    chk({tag, "_end_dqout"}, dqout, 0);
    chk({tag, "_end_ready"}, cmd_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd = 2'd0; cmd_ap = 1'b0;
    row = '0; column = '0; dqin = '0;
    tick();
    tick();
    chk("rst_ready", cmd_ready, 1);
    chk("rst_dq_valid", dq_valid, 0);
    chk("rst_dqout", dqout, 0);
    chk("rst_cmd_err", cmd_err, 0);
    chk("rst_row_open", row_open, 0);
    chk("rst_open_row", open_row, 0);
    rst_n = 1'b1;
    tick();

    // Open row 5, write 1..8 into columns 0..7, and read them back with and without a wrap.
    act(6'd5);
    wr_burst(7'd0, 32'h8765_4321);
    rd_burst("rd_c0", 7'd0, 32'h8765_4321);
    rd_burst("rd_c5", 7'd5, 32'h5432_1876);

    // ACT while ACTIVE is illegal. The state and the open row must not change.
    issue(2'd0, 6'd9, 7'd0, 1'b0);
    chk("act_active_err", cmd_err, 1);
    chk("act_active_ready", cmd_ready, 1);
    chk("act_active_open_row", open_row, 5);
    chk("act_active_row_open", row_open, 1);
    tick();
    chk("act_active_err_clr", cmd_err, 0);
    chk("act_active_dq_valid", dq_valid, 0);

    // PRE closes the row. cmd_ready returns at T+3 and open_row is held.
    issue(2'd3, 6'd0, 7'd0, 1'b0);
    chk("pre_ready_T", cmd_ready, 0);
    chk("pre_row_open", row_open, 0);
    tick();
    tick();
    chk("pre_ready_T2", cmd_ready, 0);
    tick();
    chk("pre_ready_T3", cmd_ready, 1);
    chk("pre_open_row_held", open_row, 5);

    // RD in IDLE is illegal. PRE in IDLE is a silent no-op.
    issue(2'd1, 6'd0, 7'd0, 1'b0);
    chk("rd_idle_err", cmd_err, 1);
    chk("rd_idle_row_open", row_open, 0);
    chk("rd_idle_ready", cmd_ready, 1);
    tick();
    chk("rd_idle_err_clr", cmd_err, 0);
    chk("rd_idle_dq_valid", dq_valid, 0);
    issue(2'd3, 6'd0, 7'd0, 1'b0);
    chk("pre_idle_err", cmd_err, 0);
    chk("pre_idle_ready", cmd_ready, 1);

    // Reset at the third read beat (edge T+6).
    act(6'd5);
    issue(2'd1, 6'd0, 7'd0, 1'b0);
    for (int k = 1; k <= 5; k++) tick();
    chk("rdrst_beat1_valid", dq_valid, 1);
    chk("rdrst_beat1_data", dqout, 2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rdrst_dq_valid", dq_valid, 0);
    chk("rdrst_dqout", dqout, 0);
    chk("rdrst_ready", cmd_ready, 1);
    chk("rdrst_row_open", row_open, 0);
    chk("rdrst_open_row", open_row, 0);
    act(6'd7);

    // Reset during a write: beats 1..3 are kept and beat 4 is not written.
    wr_burst(7'd16, 32'hFFFF_FFFF);
    issue(2'd2, 6'd0, 7'd16, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      dqin = 4'(i);
      tick();
    end
    dqin = 4'd4;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("wrrst_ready", cmd_ready, 1);
    chk("wrrst_row_open", row_open, 0);
    act(6'd7);
    rd_burst("rd_wrrst", 7'd16, 32'hFFFF_F321);

`ifdef BANK_AUTOPRE_EN
    // WR with auto-precharge: the row closes at T+9 and cmd_ready returns at T+12.
    issue(2'd2, 6'd0, 7'd32, 1'b1);
    for (int i = 0; i < 8; i++) begin
      dqin = 4'(i);
      tick();
    end
    tick();
    chk("ap_row_open_T9", row_open, 0);
    chk("ap_ready_T9", cmd_ready, 0);
    tick();
    tick();
    chk("ap_ready_T11", cmd_ready, 0);
    tick();
    chk("ap_ready_T12", cmd_ready, 1);
    issue(2'd1, 6'd0, 7'd0, 1'b0);
    chk("ap_rd_idle_err", cmd_err, 1);
`else
    // Without auto-precharge, cmd_ap is ignored and the bank returns to ACTIVE.
    issue(2'd2, 6'd0, 7'd32, 1'b1);
    for (int i = 0; i < 8; i++) begin
      dqin = 4'(i);
      tick();
    end
    tick();
    chk("noap_ready_T9", cmd_ready, 1);
    chk("noap_row_open_T9", row_open, 1);
    issue(2'd3, 6'd0, 7'd0, 1'b0);
    chk("noap_pre_err", cmd_err, 0);
    chk("noap_pre_row_open", row_open, 0);
`endif

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
